adder_accumulator: RTL and testbench
====================================

ADDER_ACCUMULATOR -- requirements
Module: adder_accumulator

Interface
REQ-001 Parameter N, default 32, SHALL set the operand and accumulator width in bits.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the beat counter and the overflow counter.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  SHALL be the reset: asynchronous, active-low.
REQ-005 in_valid  in  1  SHALL indicate that an operand beat is presented.
REQ-006 in_ready  out  1  SHALL indicate that the block can accept a beat.
REQ-007 in_data  in  N  SHALL carry a two's-complement operand.
REQ-008 in_last  in  1  SHALL mark the final beat of a packet.
REQ-009 out_valid  out  1  SHALL indicate that the packet result is held on the outputs.
REQ-010 out_ready  in  1  SHALL be the consumer's acceptance of the result.
REQ-011 out_sum  out  N  SHALL carry the accumulated sum modulo 2^N.
REQ-012 out_carry  out  1  SHALL be the sticky OR of the unsigned carry-out over the packet.
REQ-013 out_of  out  1  SHALL be the sticky OR of the signed overflow over the packet.
REQ-014 out_of_count  out  CNT_W  SHALL give the number of additions that overflowed, saturating at all-ones.
REQ-015 out_count  out  CNT_W  SHALL give the number of beats accepted, saturating at all-ones.

Function
REQ-016 The FSM SHALL have three states: IDLE, ACCUM and HOLD.
REQ-017 in_ready SHALL be 1 in IDLE and ACCUM, and 0 in HOLD; it is decoded combinationally from state.
REQ-018 A beat SHALL be accepted only on a cycle where in_valid and in_ready are both 1; in_data is ignored otherwise.
REQ-019 Adder operands SHALL be: a = 0 in IDLE, otherwise the accumulator; b = in_data.
REQ-020 Sum, carry and overflow SHALL come from a single combinational adder instance.
REQ-021 Accept in IDLE:
  - acc <= sum; count <= 1
  - sticky carry, sticky overflow and of_count cleared, then updated with this addition's flags (always 0 for this addition)
  - next state is HOLD if in_last, otherwise ACCUM.
REQ-022 Accept in ACCUM:
  - acc <= sum, wrapping modulo 2^N
  - carry and overflow flags ORed into the sticky bits
  - of_count incremented when overflow occurs; count incremented
  - next state is HOLD if in_last, otherwise stay in ACCUM.
REQ-023 Both counters SHALL saturate at 2^CNT_W-1; they never wrap.
REQ-024 Overflow SHALL be set when both operands have the same sign and the sum's sign differs; carry SHALL be the bit-N carry-out.
REQ-025 out_valid SHALL be 1 exactly while in HOLD, starting the cycle after the last beat is accepted (latency 1).
REQ-026 All result outputs SHALL be registered and SHALL stay stable throughout HOLD.
REQ-027 In HOLD with out_ready=1, the next state SHALL be IDLE; with out_ready=0, the block SHALL stay in HOLD indefinitely.
REQ-028 in_valid asserted during HOLD SHALL be ignored and not accepted.
REQ-029 In IDLE or ACCUM with in_valid=0, state and registers SHALL hold.
REQ-030 out_ready SHALL be ignored outside HOLD.
REQ-031 Result outputs SHALL keep their last values after returning to IDLE, until overwritten by the next packet.

Reset
REQ-032 While rst_n=0, the block SHALL be in IDLE with acc, out_sum, out_carry, out_of, out_of_count, out_count and out_valid all 0.
REQ-033 in_ready SHALL be 1 immediately after reset is released.
REQ-034 Reset asserted mid-packet or during HOLD SHALL discard the partial or held result; no beat is accepted while rst_n=0.

Structure
REQ-035 The shared package adder_pkg SHALL hold the default N, the default CNT_W and the FSM state encoding (IDLE=0, ACCUM=1, HOLD=2).
REQ-036 The adder SHALL be one instance of the team's existing CLA module (ports a, b, sum, carry, overflow); no other sub-module is used.

Verification
REQ-037 Single beat 0x00000005 with last -> next cycle out_valid=1, out_sum=0x00000005, out_carry=0, out_of=0, out_count=1.
REQ-038 Beats 1, 2, 3 (last on 3), in_valid gapped by one idle cycle -> out_sum=0x00000006, out_count=3, out_of_count=0.
REQ-039 Beats 0x7FFFFFFF, 0x00000001 -> out_sum=0x80000000, out_of=1, out_carry=0, out_of_count=1.
REQ-040 Beats 0xC0000000, 0x80000000 -> out_sum=0x40000000, out_of=1, out_carry=1.
REQ-041 Backpressure: out_ready=0 for 5 cycles with in_valid=1 -> out_valid and outputs held, in_ready=0, nothing accepted; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-042 rst_n pulsed low after 2 accepted beats, then packet 0x00000009 with last -> all outputs 0 during reset, then out_sum=0x00000009, out_count=1.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared definitions for the adder/accumulator slice: default widths and FSM encoding.
package adder_pkg;

   localparam int unsigned DEF_N     = 32;
   localparam int unsigned DEF_CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } accStateT;

endpackage

// File: rtl/adder_accumulator_cla.sv
// Generate/propagate adder with unsigned carry-out and signed overflow flags.
module adder_accumulator_cla
   import adder_pkg::*;
#(
   parameter int unsigned N = DEF_N
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic [N-1:0] sum,
   output logic         carry,
   output logic         overflow
);

   logic [N-1:0] gen;
   logic [N-1:0] prop;
   logic [N:0]   c;

   always_comb begin
      gen  = a & b;
      prop = a ^ b;
      c    = '0;
      for (int unsigned i = 0; i < N; i++) begin
         c[i+1] = gen[i] | (prop[i] & c[i]);
      end
      sum      = prop ^ c[N-1:0];
      carry    = c[N];
      // Same-sign operands whose result sign differs.
      overflow = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
   end

endmodule

// File: rtl/adder_accumulator.sv
// Packet accumulator: sums operand beats until in_last, then holds the result until out_ready.
module adder_accumulator
   import adder_pkg::*;
#(
   parameter int unsigned N     = DEF_N,
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [N-1:0]     in_data,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [N-1:0]     out_sum,
   output logic             out_carry,
   output logic             out_of,
   output logic [CNT_W-1:0] out_of_count,
   output logic [CNT_W-1:0] out_count
);

   accStateT         state, stateNext;
   logic [N-1:0]     acc, accNext;
   logic             carrySticky, carryNext;
   logic             ofSticky, ofNext;
   logic [CNT_W-1:0] ofCount, ofCountNext;
   logic [CNT_W-1:0] count, countNext;
   logic [N-1:0]     addA, addSum;
   logic             addCarry, addOf;
   logic             accept;

   adder_accumulator_cla #(.N(N)) uCla (
      .a        (addA),
      .b        (in_data),
      .sum      (addSum),
      .carry    (addCarry),
      .overflow (addOf)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext   = state;
      accNext     = acc;
      carryNext   = carrySticky;
      ofNext      = ofSticky;
      ofCountNext = ofCount;
      countNext   = count;
      in_ready    = (state != HOLD);
      accept      = in_valid && in_ready;
      addA        = (state == IDLE) ? '0 : acc;
      case (state)
         IDLE: if (accept) begin
            accNext     = addSum;
            countNext   = CNT_W'(1);
            carryNext   = addCarry;
            ofNext      = addOf;
            ofCountNext = addOf ? CNT_W'(1) : '0;
            stateNext   = in_last ? HOLD : ACCUM;
         end
         ACCUM: if (accept) begin
            accNext   = addSum;
            carryNext = carrySticky | addCarry;
            ofNext    = ofSticky | addOf;
            if (addOf && (ofCount != '1)) ofCountNext = ofCount + 1'b1;
            if (count != '1)              countNext   = count + 1'b1;
            stateNext = in_last ? HOLD : ACCUM;
         end
         HOLD: if (out_ready) stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Result outputs load only on the final beat so they stay put through HOLD and IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc          <= '0;
         carrySticky  <= 1'b0;
         ofSticky     <= 1'b0;
         ofCount      <= '0;
         count        <= '0;
         out_valid    <= 1'b0;
         out_sum      <= '0;
         out_carry    <= 1'b0;
         out_of       <= 1'b0;
         out_of_count <= '0;
         out_count    <= '0;
      end else begin
         acc         <= accNext;
         carrySticky <= carryNext;
         ofSticky    <= ofNext;
         ofCount     <= ofCountNext;
         count       <= countNext;
         out_valid   <= (stateNext == HOLD);
         if (accept && in_last) begin
            out_sum      <= accNext;
            out_carry    <= carryNext;
            out_of       <= ofNext;
            out_of_count <= ofCountNext;
            out_count    <= countNext;
         end
      end
   end

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed bench for adder_accumulator with hand-computed expectations.
module tb_adder_accumulator;

   localparam int unsigned N     = 32;
   localparam int unsigned CNT_W = 8;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_data;
   logic             in_last;
   logic             out_valid;
   logic             out_ready;
   logic [N-1:0]     out_sum;
   logic             out_carry;
   logic             out_of;
   logic [CNT_W-1:0] out_of_count;
   logic [CNT_W-1:0] out_count;

   int vectors = 0;
   int miscompares = 0;

   adder_accumulator #(.N(N), .CNT_W(CNT_W)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_last      (in_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_sum      (out_sum),
      .out_carry    (out_carry),
      .out_of       (out_of),
      .out_of_count (out_of_count),
      .out_count    (out_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [N-1:0] d, input logic last);
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_data  = '0;
   endtask

   task automatic release_result();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic check_result(input string tag, input logic [N-1:0] s, input logic c,
                               input logic o, input logic [CNT_W-1:0] oc,
                               input logic [CNT_W-1:0] cnt);
      check({tag, ".valid"}, out_valid, 1'b1);
      check({tag, ".sum"}, out_sum, s);
      check({tag, ".carry"}, out_carry, c);
      check({tag, ".of"}, out_of, o);
      check({tag, ".ofcnt"}, out_of_count, oc);
      check({tag, ".count"}, out_count, cnt);
      check({tag, ".ready"}, in_ready, 1'b0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      tick();
      tick();
      check("rst.valid", out_valid, 1'b0);
      check("rst.sum", out_sum, 32'h0);
      check("rst.carry", out_carry, 1'b0);
      check("rst.of", out_of, 1'b0);
      check("rst.ofcnt", out_of_count, 8'h0);
      check("rst.count", out_count, 8'h0);
      rst_n = 1'b1;
      #1;
      check("rst.ready", in_ready, 1'b1);

      // Single beat with last.
      beat(32'h5, 1'b1);
      check_result("single", 32'h5, 1'b0, 1'b0, 8'd0, 8'd1);
      release_result();
      check("single.idle_valid", out_valid, 1'b0);
      check("single.idle_ready", in_ready, 1'b1);
      check("single.keep_sum", out_sum, 32'h5);

      // Gapped beats 1, 2, 3.
      beat(32'h1, 1'b0);
      tick();
      check("gap.valid_mid", out_valid, 1'b0);
      beat(32'h2, 1'b0);
      tick();
      beat(32'h3, 1'b1);
      check_result("gap", 32'h6, 1'b0, 1'b0, 8'd0, 8'd3);
      release_result();

      // Signed overflow, no carry.
      beat(32'h7FFF_FFFF, 1'b0);
      beat(32'h0000_0001, 1'b1);
      check_result("ovf", 32'h8000_0000, 1'b0, 1'b1, 8'd1, 8'd2);
      release_result();

      // Both negative: carry and overflow.
      beat(32'hC000_0000, 1'b0);
      beat(32'h8000_0000, 1'b1);
      check_result("negovf", 32'h4000_0000, 1'b1, 1'b1, 8'd1, 8'd2);
      release_result();

      // Backpressure with in_valid held high during HOLD.
      beat(32'h10, 1'b1);
      in_valid = 1'b1;
      in_data  = 32'h55;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp.valid", out_valid, 1'b1);
         check("bp.sum", out_sum, 32'h10);
         check("bp.count", out_count, 8'd1);
         check("bp.ready", in_ready, 1'b0);
      end
      out_ready = 1'b1;
      tick();
      in_valid  = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b0;
      check("bp.rel_valid", out_valid, 1'b0);
      check("bp.rel_ready", in_ready, 1'b1);
      check("bp.rel_sum", out_sum, 32'h10);

      // Reset mid-packet discards the partial sum.
      beat(32'h4, 1'b0);
      beat(32'h6, 1'b0);
      rst_n = 1'b0;
      #1;
      check("midrst.sum", out_sum, 32'h0);
      check("midrst.count", out_count, 8'd0);
      check("midrst.valid", out_valid, 1'b0);
      in_valid = 1'b1;
      in_data  = 32'h77;
      in_last  = 1'b1;
      tick();
      check("midrst.noacc", out_valid, 1'b0);
      check("midrst.sum2", out_sum, 32'h0);
      in_valid = 1'b0;
      in_last  = 1'b0;
      rst_n    = 1'b1;
      tick();
      beat(32'h9, 1'b1);
      check_result("postrst", 32'h9, 1'b0, 1'b0, 8'd0, 8'd1);
      release_result();

      // Beat counter saturates at all-ones; sum keeps counting.
      for (int i = 0; i < 299; i++) beat(32'h1, 1'b0);
      beat(32'h1, 1'b1);
      check_result("sat", 32'd300, 1'b0, 1'b0, 8'd0, 8'hFF);
      release_result();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
